// File: rtl/dcache_controller_if.sv
// Bus bundle for the L1 data-cache controller: CPU memory stage, cache SRAM
// array and off-chip data memory. The master modport is the controller's view;
// the slave modport is the view of the surrounding CPU/SRAM/memory.
interface dcache_controller_if #(
   parameter int INDEX_BITS = 4,
   parameter int TAG_BITS   = 23,
   parameter int LINE_BITS  = 256
);
   logic [31:0]             cpu_addr_i;
   logic [31:0]             cpu_data_i;
   logic                    cpu_MemRead_i;
   logic                    cpu_MemWrite_i;
   logic [31:0]             cpu_data_o;
   logic                    cpu_stall_o;

   logic [INDEX_BITS-1:0]   sram_addr_o;
   logic [TAG_BITS+1:0]     sram_tag_o;
   logic [LINE_BITS-1:0]    sram_data_o;
   logic                    sram_enable_o;
   logic                    sram_write_o;
   logic [TAG_BITS+1:0]     sram_tag_i;
   logic [LINE_BITS-1:0]    sram_data_i;
   logic                    sram_hit_i;

   logic [31:0]             mem_addr_o;
   logic [LINE_BITS-1:0]    mem_data_o;
   logic                    mem_enable_o;
   logic                    mem_write_o;
   logic [LINE_BITS-1:0]    mem_data_i;
   logic                    mem_ack_i;

   modport master (
      input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
      output cpu_data_o, cpu_stall_o,
      output sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
      input  sram_tag_i, sram_data_i, sram_hit_i,
      output mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
      input  mem_data_i, mem_ack_i
   );

   modport slave (
      output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
      input  cpu_data_o, cpu_stall_o,
      input  sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
      output sram_tag_i, sram_data_i, sram_hit_i,
      input  mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
      output mem_data_i, mem_ack_i
   );
endinterface

// File: rtl/dcache_controller.sv
// Controller for the 2-way set-associative L1 data cache. Hits complete in the
// access cycle with no stall; misses write back a dirty victim, refill the line
// from memory, then replay the access as a hit (write-allocate for stores).
//
// state      | meaning
// -----------+----------------------------------------------------------------
// IDLE       | resolve the CPU access against the SRAM; miss latches line addr
// MISS       | victim visible on the SRAM port; launch write-back or refill
// WRITEBACK  | dirty victim write in flight; its ack launches the refill read
// READMISS   | refill read in flight; its ack writes the line into the SRAM
// READMISSOK | one settle cycle, then IDLE replays the access as a hit
module dcache_controller #(
   parameter int INDEX_BITS = 4,
   parameter int TAG_BITS   = 23,
   parameter int LINE_BITS  = 256
) (
   input  logic                clk_i,
   input  logic                rst_i,
   dcache_controller_if.master bus
);
   localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);
   localparam int WORD_BITS   = $clog2(LINE_BITS / 32);
   localparam int LADDR_BITS  = TAG_BITS + INDEX_BITS;

   typedef enum logic [2:0] {
      IDLE,
      MISS,
      WRITEBACK,
      READMISS,
      READMISSOK
   } state_t;

   state_t                  state_q, state_d;
   logic [LADDR_BITS-1:0]   miss_addr_q, miss_addr_d;
   logic                    mem_enable_q, mem_enable_d;
   logic                    mem_write_q, mem_write_d;
   logic [31:0]             mem_addr_q, mem_addr_d;
   logic [LINE_BITS-1:0]    mem_data_q, mem_data_d;

   logic                    req;
   logic [INDEX_BITS-1:0]   index;
   logic [WORD_BITS-1:0]    word_sel;
   logic [TAG_BITS-1:0]     cpu_tag;
   logic                    victim_dirty;
   logic [LINE_BITS-1:0]    store_line;

   logic                    cpu_stall;
   logic                    sram_write;
   logic [TAG_BITS+1:0]     sram_tag;
   logic [LINE_BITS-1:0]    sram_data;

   logic                    unused_addr_bits;

   assign req          = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
   assign index        = bus.cpu_addr_i[OFFSET_BITS +: INDEX_BITS];
   assign word_sel     = bus.cpu_addr_i[2 +: WORD_BITS];
   assign cpu_tag      = bus.cpu_addr_i[31 -: TAG_BITS];
   assign victim_dirty = bus.sram_tag_i[TAG_BITS+1] & bus.sram_tag_i[TAG_BITS];
   assign unused_addr_bits = ^bus.cpu_addr_i[1:0];

   // Store-hit line: the SRAM line with the addressed word replaced by CPU data.
   always_comb begin
      store_line = bus.sram_data_i;
      store_line[{word_sel, 5'd0} +: 32] = bus.cpu_data_i;
   end

   // Next-state logic, combinational SRAM strobe and next values of the mem regs.
   always_comb begin
      state_d      = state_q;
      miss_addr_d  = miss_addr_q;
      mem_enable_d = mem_enable_q;
      mem_write_d  = mem_write_q;
      mem_addr_d   = mem_addr_q;
      mem_data_d   = mem_data_q;
      cpu_stall    = 1'b1;
      sram_write   = 1'b0;
      sram_tag     = {2'b11, cpu_tag};
      sram_data    = store_line;

      case (state_q)
         IDLE: begin
            cpu_stall = req & ~bus.sram_hit_i;
            if (bus.cpu_MemWrite_i & bus.sram_hit_i) begin
               sram_write = 1'b1;
            end
            if (req & ~bus.sram_hit_i) begin
               miss_addr_d = bus.cpu_addr_i[31:OFFSET_BITS];
               state_d     = MISS;
            end
         end
         MISS: begin
            mem_enable_d = 1'b1;
            if (victim_dirty) begin
               mem_write_d = 1'b1;
               mem_addr_d  = {bus.sram_tag_i[TAG_BITS-1:0], miss_addr_q[INDEX_BITS-1:0],
                              {OFFSET_BITS{1'b0}}};
               mem_data_d  = bus.sram_data_i;
               state_d     = WRITEBACK;
            end else begin
               mem_write_d = 1'b0;
               mem_addr_d  = {miss_addr_q, {OFFSET_BITS{1'b0}}};
               state_d     = READMISS;
            end
         end
         WRITEBACK: begin
            if (bus.mem_ack_i) begin
               mem_write_d = 1'b0;
               mem_addr_d  = {miss_addr_q, {OFFSET_BITS{1'b0}}};
               state_d     = READMISS;
            end
         end
         READMISS: begin
            // A reset landing on the ack cycle must not leave a half-refilled line.
            if (bus.mem_ack_i & ~rst_i) begin
               sram_write   = 1'b1;
               sram_tag     = {2'b10, miss_addr_q[INDEX_BITS +: TAG_BITS]};
               sram_data    = bus.mem_data_i;
               mem_enable_d = 1'b0;
               state_d      = READMISSOK;
            end
         end
         READMISSOK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register and registered memory-request outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         miss_addr_q  <= '0;
         mem_enable_q <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         miss_addr_q  <= miss_addr_d;
         mem_enable_q <= mem_enable_d;
         mem_write_q  <= mem_write_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
      end
   end

   assign bus.cpu_data_o    = bus.sram_data_i[{word_sel, 5'd0} +: 32];
   assign bus.cpu_stall_o   = cpu_stall;
   assign bus.sram_addr_o   = index;
   assign bus.sram_enable_o = req;
   assign bus.sram_write_o  = sram_write;
   assign bus.sram_tag_o    = sram_tag;
   assign bus.sram_data_o   = sram_data;
   assign bus.mem_enable_o  = mem_enable_q;
   assign bus.mem_write_o   = mem_write_q;
   assign bus.mem_addr_o    = mem_addr_q;
   assign bus.mem_data_o    = mem_data_q;
endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: 2-way LRU SRAM model, fixed-latency memory model,
// a table of CPU accesses checked through an expectation queue, and a
// hand-written reset-during-refill sequence.
module tb_dcache_controller;
   localparam int L = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dcache_controller_if bus();

   dcache_controller dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[15:0] ^ 16'hA5C3};
   endfunction

   function automatic logic [255:0] mem_line(input logic [31:0] a);
      logic [255:0] l;
      logic [31:0]  base;
      base = {a[31:5], 5'b0};
      for (int j = 0; j < 8; j++) l[j*32 +: 32] = mem_word(base + 32'(j * 4));
      return l;
   endfunction

   // ---------------- SRAM model: 16 sets x 2 ways, one LRU bit per set
   logic [24:0]  tag_arr [2][16];
   logic [255:0] dat_arr [2][16];
   logic         lru     [16];
   logic         sram_clr = 1'b1;
   int           sram_wr_cnt = 0;
   logic [3:0]   set_i;
   logic         h0, h1, wway;

   always_comb begin
      set_i = bus.sram_addr_o;
      h0 = tag_arr[0][set_i][24] && (tag_arr[0][set_i][22:0] == bus.sram_tag_o[22:0]);
      h1 = tag_arr[1][set_i][24] && (tag_arr[1][set_i][22:0] == bus.sram_tag_o[22:0]);
      wway = h0 ? 1'b0 : (h1 ? 1'b1 : lru[set_i]);
      bus.sram_hit_i  = h0 | h1;
      bus.sram_tag_i  = tag_arr[wway][set_i];
      bus.sram_data_i = dat_arr[wway][set_i];
   end

   always @(posedge clk) begin
      if (bus.sram_write_o) sram_wr_cnt <= sram_wr_cnt + 1;
      if (sram_clr) begin
         for (int w = 0; w < 2; w++)
            for (int s = 0; s < 16; s++) begin
               tag_arr[w][s] <= '0;
               dat_arr[w][s] <= '0;
            end
         for (int s = 0; s < 16; s++) lru[s] <= 1'b0;
      end else if (bus.sram_enable_o) begin
         if (bus.sram_write_o) begin
            tag_arr[wway][set_i] <= bus.sram_tag_o;
            dat_arr[wway][set_i] <= bus.sram_data_o;
         end
         if (bus.sram_hit_i | bus.sram_write_o) lru[set_i] <= ~wway;
      end
   end

   // ---------------- memory model: ack in the L-th cycle of a request
   typedef struct {
      bit           wr;
      logic [31:0]  addr;
      logic [255:0] data;
   } mem_txn_t;

   logic [255:0] mem_store [logic [31:0]];
   mem_txn_t     obs_q[$];
   bit           mem_auto = 1'b1;
   logic         man_ack  = 1'b0;
   logic [255:0] man_data = '0;
   int           mcnt     = 0;

   initial begin
      bus.mem_ack_i  = 1'b0;
      bus.mem_data_i = '0;
      forever begin
         @(posedge clk);
         #1;
         if (mem_auto) begin
            bus.mem_ack_i  = 1'b0;
            bus.mem_data_i = '0;
            if (bus.mem_enable_o) begin
               mcnt++;
               if (mcnt == L) begin
                  mcnt = 0;
                  bus.mem_ack_i = 1'b1;
                  if (bus.mem_write_o) mem_store[bus.mem_addr_o] = bus.mem_data_o;
                  else if (mem_store.exists(bus.mem_addr_o)) bus.mem_data_i = mem_store[bus.mem_addr_o];
                  else bus.mem_data_i = mem_line(bus.mem_addr_o);
                  obs_q.push_back('{bus.mem_write_o, bus.mem_addr_o, bus.mem_data_o});
               end
            end else begin
               mcnt = 0;
            end
         end else begin
            mcnt = 0;
            bus.mem_ack_i  = man_ack;
            bus.mem_data_i = man_data;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- access table
   typedef struct {
      bit           rd;
      bit           wr;
      logic [31:0]  addr;
      logic [31:0]  wdata;
      bit           chk_data;
      logic [31:0]  exp_data;
      int           exp_stall;
      bit           exp_wb;
      logic [31:0]  wb_addr;
      logic [255:0] wb_data;
      bit           exp_rd;
      logic [31:0]  rd_addr;
   } vec_t;

   function automatic vec_t mk(input bit rd, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit chk,
                               input logic [31:0] exp_data, input int stall,
                               input bit wb, input logic [31:0] wb_addr,
                               input logic [255:0] wb_data, input bit rdm,
                               input logic [31:0] rd_addr);
      vec_t v;
      v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
      v.chk_data = chk; v.exp_data = exp_data; v.exp_stall = stall;
      v.exp_wb = wb; v.wb_addr = wb_addr; v.wb_data = wb_data;
      v.exp_rd = rdm; v.rd_addr = rd_addr;
      return v;
   endfunction

   vec_t vecs[$];
   vec_t exp_q[$];

   initial begin
      logic [255:0] dirty_line;
      vec_t         e;
      int           stalls, idx, w_seen;
      bit           done;
      logic [31:0]  got_data;
      logic         got_wr;
      int           wcnt0;

      dirty_line = mem_line(32'h100);
      dirty_line[64 +: 32] = 32'hDEAD_BEEF;

      vecs.push_back(mk(1, 0, 32'h0000_0100, 0, 1, mem_word(32'h100),  L + 3,     0, 0, 0, 1, 32'h100));
      vecs.push_back(mk(1, 0, 32'h0000_0104, 0, 1, mem_word(32'h104),  0,         0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 32'h0000_0108, 32'hDEAD_BEEF, 0, 0,      0,         0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 32'h0000_0108, 0, 1, 32'hDEAD_BEEF,      0,         0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 32'h0000_2100, 0, 1, mem_word(32'h2100), L + 3,     0, 0, 0, 1, 32'h2100));
      vecs.push_back(mk(1, 0, 32'h0000_4100, 0, 1, mem_word(32'h4100), 2 * L + 3, 1, 32'h100, dirty_line, 1, 32'h4100));
      vecs.push_back(mk(1, 0, 32'h0000_0108, 0, 1, 32'hDEAD_BEEF,      L + 3,     0, 0, 0, 1, 32'h100));
      vecs.push_back(mk(0, 1, 32'h0000_6200, 32'h1234_5678, 0, 0,      L + 3,     0, 0, 0, 1, 32'h6200));
      vecs.push_back(mk(1, 0, 32'h0000_6200, 0, 1, 32'h1234_5678,      0,         0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 32'h0000_6204, 32'hCAFE_F00D, 0, 0,      0,         0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 32'h0000_6204, 0, 1, 32'hCAFE_F00D,      0,         0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 32'h0000_621C, 0, 1, mem_word(32'h621C), 0,         0, 0, 0, 0, 0));

      bus.cpu_addr_i     = '0;
      bus.cpu_data_i     = '0;
      bus.cpu_MemRead_i  = 1'b0;
      bus.cpu_MemWrite_i = 1'b0;
      rst      = 1'b1;
      sram_clr = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst      = 1'b0;
      sram_clr = 1'b0;

      @(negedge clk);
      check("rst_stall",      bus.cpu_stall_o,  0);
      check("rst_sram_write", bus.sram_write_o, 0);
      check("rst_cpu_data",   bus.cpu_data_o,   0);
      check("rst_mem_enable", bus.mem_enable_o, 0);
      check("rst_mem_write",  bus.mem_write_o,  0);
      check("rst_mem_addr",   bus.mem_addr_o,   0);
      check("rst_mem_data",   bus.mem_data_o,   0);
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         exp_q.push_back(vecs[i]);
         obs_q.delete();
         bus.cpu_addr_i     = vecs[i].addr;
         bus.cpu_data_i     = vecs[i].wdata;
         bus.cpu_MemRead_i  = vecs[i].rd;
         bus.cpu_MemWrite_i = vecs[i].wr;
         stalls = 0;
         done   = 1'b0;
         for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!bus.cpu_stall_o) begin
               done = 1'b1;
               break;
            end
            stalls++;
         end
         got_data = bus.cpu_data_o;
         got_wr   = bus.sram_write_o;
         @(posedge clk);
         #1;
         bus.cpu_MemRead_i  = 1'b0;
         bus.cpu_MemWrite_i = 1'b0;

         e = exp_q.pop_front();
         check($sformatf("v%0d_complete", i), done, 1);
         check($sformatf("v%0d_stall", i), stalls, e.exp_stall);
         check($sformatf("v%0d_hit_write", i), got_wr, e.wr);
         if (e.chk_data) check($sformatf("v%0d_data", i), got_data, e.exp_data);
         check($sformatf("v%0d_txn_count", i), obs_q.size(), 32'(int'(e.exp_wb) + int'(e.exp_rd)));
         idx = 0;
         if (e.exp_wb) begin
            if (obs_q.size() > idx) begin
               check($sformatf("v%0d_wb_is_write", i), obs_q[idx].wr, 1);
               check($sformatf("v%0d_wb_addr", i), obs_q[idx].addr, e.wb_addr);
               check($sformatf("v%0d_wb_data", i), obs_q[idx].data, e.wb_data);
            end
            idx++;
         end
         if (e.exp_rd) begin
            if (obs_q.size() > idx) begin
               check($sformatf("v%0d_rd_is_read", i), obs_q[idx].wr, 0);
               check($sformatf("v%0d_rd_addr", i), obs_q[idx].addr, e.rd_addr);
            end
            idx++;
         end
      end

      // Stored-into line is dirty, refilled-only line is clean.
      w_seen = 0;
      for (int w = 0; w < 2; w++)
         if (tag_arr[w][0][22:0] == 23'h31) begin
            w_seen++;
            check("tag_6200_valid_dirty", tag_arr[w][0][24:23], 2'b11);
         end
      check("tag_6200_present", w_seen, 1);
      w_seen = 0;
      for (int w = 0; w < 2; w++)
         if (tag_arr[w][8][22:0] == 23'h20) begin
            w_seen++;
            check("tag_4100_valid_clean", tag_arr[w][8][24:23], 2'b10);
         end
      check("tag_4100_present", w_seen, 1);

      // Reset while a refill is outstanding; the late ack must be ignored.
      mem_auto = 1'b0;
      man_ack  = 1'b0;
      bus.cpu_addr_i    = 32'h0000_A040;
      bus.cpu_MemRead_i = 1'b1;
      done = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.mem_enable_o) begin
            done = 1'b1;
            break;
         end
      end
      check("rm_enable_seen", done, 1);
      repeat (3) @(negedge clk);
      check("rm_stalled", bus.cpu_stall_o, 1);
      check("rm_read_pending", {bus.mem_enable_o, bus.mem_write_o}, 2'b10);
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus.cpu_MemRead_i = 1'b0;
      @(posedge clk);
      man_ack  = 1'b1;
      man_data = '1;
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rm_enable_dropped", bus.mem_enable_o, 0);
      check("rm_idle_no_stall", bus.cpu_stall_o, 0);
      check("rm_late_ack_no_write", bus.sram_write_o, 0);
      wcnt0 = sram_wr_cnt;
      @(posedge clk);
      man_ack  = 1'b0;
      man_data = '0;
      @(negedge clk);
      check("rm_enable_still_low", bus.mem_enable_o, 0);
      check("rm_sram_write_count", sram_wr_cnt, wcnt0);
      check("rm_set2_way0_invalid", tag_arr[0][2][24], 0);
      check("rm_set2_way1_invalid", tag_arr[1][2][24], 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
